// File: rtl/mdr_sequencer.sv
// Control FSM for the shared multiply/divide/square-root datapaths: latches a request,
// sequences init/enable/counter for the op's iteration count, and captures the result.
module mdr_sequencer #(
  parameter int DW        = 16,
  parameter int DW2       = 32,
  parameter int ITER_MUL  = 16,
  parameter int ITER_DIV  = 16,
  parameter int ITER_ROOT = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           i_start,
  input  logic [1:0]     i_op,
  input  logic [DW-1:0]  i_data_x,
  input  logic [DW-1:0]  i_data_y,
  input  logic           i_clear,
  input  logic [DW2-1:0] i_result,
  input  logic [DW2-1:0] i_reminder,
  output logic           o_ready,
  output logic [1:0]     o_sel,
  output logic [DW-1:0]  o_val_x,
  output logic [DW-1:0]  o_val_y,
  output logic           o_init,
  output logic           o_enable,
  output logic [7:0]     o_counter,
  output logic [DW2-1:0] o_result,
  output logic [DW2-1:0] o_reminder,
  output logic           o_done,
  output logic           o_error
);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_RUN, S_CAPT, S_DONE, S_ERR} state_t;

  localparam logic [1:0] OP_MUL = 2'b00;
  localparam logic [1:0] OP_DIV = 2'b01;
  localparam logic [1:0] OP_RSV = 2'b11;
  localparam logic [7:0] LAST_MUL  = 8'(ITER_MUL - 1);
  localparam logic [7:0] LAST_DIV  = 8'(ITER_DIV - 1);
  localparam logic [7:0] LAST_ROOT = 8'(ITER_ROOT - 1);

  state_t         state_q, state_d;
  logic           ready_q, ready_d;
  logic [1:0]     sel_q, sel_d;
  logic [DW-1:0]  x_q, x_d;
  logic [DW-1:0]  y_q, y_d;
  logic           init_q, init_d;
  logic           enable_q, enable_d;
  logic [7:0]     counter_q, counter_d;
  logic [DW2-1:0] result_q, result_d;
  logic [DW2-1:0] rem_q, rem_d;
  logic           done_q, done_d;
  logic           error_q, error_d;
  logic           accept;

  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    x_d       = x_q;
    y_d       = y_q;
    counter_d = counter_q;
    result_d  = result_q;
    rem_d     = rem_q;
    error_d   = error_q;
    accept    = 1'b0;

    case (state_q)
      S_IDLE: accept = i_start;
      S_LOAD: state_d = S_RUN;
      S_RUN: begin
        if (counter_q == 8'd0) state_d = S_CAPT;
        else                   counter_d = counter_q - 8'd1;
      end
      S_CAPT: begin
        result_d = i_result;
        rem_d    = i_reminder;
        state_d  = S_DONE;
      end
      S_ERR: begin
        error_d = 1'b1;
        if (sel_q == OP_RSV) begin
          result_d = '0;
          rem_d    = '0;
        end else begin
          result_d = '1;
          rem_d    = {{(DW2-DW){1'b0}}, x_q};
        end
        state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
        accept  = i_start;
      end
      default: state_d = S_IDLE;
    endcase

    if (accept) begin
      sel_d   = i_op;
      x_d     = i_data_x;
      y_d     = i_data_y;
      error_d = 1'b0;
      if (i_op == OP_RSV || (i_op == OP_DIV && i_data_y == '0)) begin
        state_d = S_ERR;
      end else begin
        state_d = S_LOAD;
        case (i_op)
          OP_MUL:  counter_d = LAST_MUL;
          OP_DIV:  counter_d = LAST_DIV;
          default: counter_d = LAST_ROOT;
        endcase
      end
    end

    // Abort wins over everything, including a start in the same cycle.
    if (i_clear) begin
      state_d   = S_IDLE;
      sel_d     = sel_q;
      x_d       = x_q;
      y_d       = y_q;
      counter_d = counter_q;
      result_d  = result_q;
      rem_d     = rem_q;
      error_d   = error_q;
    end

    ready_d  = (state_d == S_IDLE) || (state_d == S_DONE);
    init_d   = (state_d == S_LOAD);
    enable_d = (state_d == S_RUN);
    done_d   = (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      ready_q   <= 1'b1;
      sel_q     <= '0;
      x_q       <= '0;
      y_q       <= '0;
      init_q    <= 1'b0;
      enable_q  <= 1'b0;
      counter_q <= '0;
      result_q  <= '0;
      rem_q     <= '0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      ready_q   <= ready_d;
      sel_q     <= sel_d;
      x_q       <= x_d;
      y_q       <= y_d;
      init_q    <= init_d;
      enable_q  <= enable_d;
      counter_q <= counter_d;
      result_q  <= result_d;
      rem_q     <= rem_d;
      done_q    <= done_d;
      error_q   <= error_d;
    end
  end

  assign o_ready    = ready_q;
  assign o_sel      = sel_q;
  assign o_val_x    = x_q;
  assign o_val_y    = y_q;
  assign o_init     = init_q;
  assign o_enable   = enable_q;
  assign o_counter  = counter_q;
  assign o_result   = result_q;
  assign o_reminder = rem_q;
  assign o_done     = done_q;
  assign o_error    = error_q;

endmodule

// File: tb/tb_mdr_sequencer.sv
// Directed bench for mdr_sequencer with a behavioural stand-in for the shared datapaths
// and a scoreboard of expected completions.
module tb_mdr_sequencer;
  localparam int DW  = 16;
  localparam int DW2 = 32;

  logic           clk = 1'b0;
  logic           rst;
  logic           i_start;
  logic [1:0]     i_op;
  logic [DW-1:0]  i_data_x, i_data_y;
  logic           i_clear;
  logic [DW2-1:0] i_result, i_reminder;
  logic           o_ready, o_init, o_enable, o_done, o_error;
  logic [1:0]     o_sel;
  logic [DW-1:0]  o_val_x, o_val_y;
  logic [7:0]     o_counter;
  logic [DW2-1:0] o_result, o_reminder;

  int tests = 0;
  int fails = 0;

  logic [DW2-1:0] exp_res_q[$];
  logic [DW2-1:0] exp_rem_q[$];
  logic           exp_err_q[$];
  int             exp_lat_q[$];

  mdr_sequencer dut (
    .clk(clk), .rst(rst), .i_start(i_start), .i_op(i_op),
    .i_data_x(i_data_x), .i_data_y(i_data_y), .i_clear(i_clear),
    .i_result(i_result), .i_reminder(i_reminder),
    .o_ready(o_ready), .o_sel(o_sel), .o_val_x(o_val_x), .o_val_y(o_val_y),
    .o_init(o_init), .o_enable(o_enable), .o_counter(o_counter),
    .o_result(o_result), .o_reminder(o_reminder), .o_done(o_done), .o_error(o_error)
  );

  always #5 clk = ~clk;

  // Datapath stand-in: answers for whatever operands the sequencer currently owns.
  int dp_x, dp_r;
  always_comb begin
    i_result   = '0;
    i_reminder = '0;
    dp_x       = int'(o_val_x);
    dp_r       = 0;
    case (o_sel)
      2'b00: i_result = {16'h0, o_val_x} * {16'h0, o_val_y};
      2'b01: begin
        if (o_val_y != '0) begin
          i_result   = {16'h0, o_val_x / o_val_y};
          i_reminder = {16'h0, o_val_x % o_val_y};
        end
      end
      2'b10: begin
        for (int r = 1; r < 256; r++) if (r * r <= dp_x) dp_r = r;
        i_result   = DW2'(dp_r);
        i_reminder = DW2'(dp_x - dp_r * dp_r);
      end
      default: ;
    endcase
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issues one op (accepted at the next edge) and follows it to its o_done cycle.
  task automatic do_op(input logic [1:0] op, input logic [DW-1:0] x, input logic [DW-1:0] y,
                       input logic [DW2-1:0] er, input logic [DW2-1:0] erem, input logic eerr,
                       input int n_en, input logic mid_start);
    int cyc, en_cnt, init_cnt, lat;
    logic seen;
    exp_res_q.push_back(er);
    exp_rem_q.push_back(erem);
    exp_err_q.push_back(eerr);
    exp_lat_q.push_back((n_en == 0) ? 2 : n_en + 3);
    check("ready_before_start", o_ready, 1);
    i_start = 1'b1; i_op = op; i_data_x = x; i_data_y = y;
    tick();
    cyc = 1; en_cnt = 0; init_cnt = 0; seen = 1'b0;
    check("init_after_accept", o_init, (n_en > 0));
    while (cyc < 40) begin
      i_start = 1'b0;
      if (o_done) begin
        seen = 1'b1;
        break;
      end
      check("sel_stable", o_sel, op);
      check("val_x_stable", o_val_x, x);
      check("val_y_stable", o_val_y, y);
      check("init_enable_excl", o_init & o_enable, 0);
      if (o_init) begin
        init_cnt++;
        check("counter_load", o_counter, n_en - 1);
      end
      if (o_enable) begin
        check("counter_run", o_counter, n_en - 1 - en_cnt);
        en_cnt++;
      end
      if (mid_start && en_cnt == 3) begin
        i_start = 1'b1; i_op = 2'b11; i_data_x = ~x; i_data_y = '0;
      end
      tick();
      cyc++;
    end
    check("done_seen", seen, 1);
    lat = exp_lat_q.pop_front();
    check("latency", cyc, lat);
    check("init_cycles", init_cnt, (n_en > 0) ? 1 : 0);
    check("enable_cycles", en_cnt, n_en);
    check("done_ready", o_ready, 1);
    check("result", o_result, exp_res_q.pop_front());
    check("reminder", o_reminder, exp_rem_q.pop_front());
    check("error", o_error, exp_err_q.pop_front());
  endtask

  int done_cnt;
  logic [DW-1:0] rx, ry;

  initial begin
    rst = 1'b1; i_start = 1'b0; i_op = '0; i_data_x = '0; i_data_y = '0; i_clear = 1'b0;
    #2 rst = 1'b0;
    #1;
    check("rst_ready", o_ready, 1);
    check("rst_done", o_done, 0);
    check("rst_counter", o_counter, 0);
    check("rst_result", o_result, 0);
    @(negedge clk);
    rst = 1'b1;
    tick();

    do_op(2'b10, 16'd144, 16'd0, 32'd12, 32'd0, 1'b0, 8, 1'b0);
    tick();
    do_op(2'b01, 16'd100, 16'd7, 32'd14, 32'd2, 1'b0, 16, 1'b1);
    do_op(2'b10, 16'd144, 16'd0, 32'd12, 32'd0, 1'b0, 8, 1'b0);
    tick();
    do_op(2'b00, 16'd300, 16'd200, 32'd60000, 32'd0, 1'b0, 16, 1'b0);
    tick();
    do_op(2'b11, 16'd7, 16'd9, 32'd0, 32'd0, 1'b1, 0, 1'b0);
    do_op(2'b01, 16'h1234, 16'd0, 32'hFFFF_FFFF, 32'h0000_1234, 1'b1, 0, 1'b0);
    tick();

    // Abort in the third RUN cycle, with a competing start.
    i_start = 1'b1; i_op = 2'b10; i_data_x = 16'd81; i_data_y = '0;
    tick();
    i_start = 1'b0;
    tick(); tick(); tick();
    check("clear_run3_enable", o_enable, 1);
    check("clear_run3_counter", o_counter, 5);
    i_clear = 1'b1; i_start = 1'b1; i_op = 2'b00; i_data_x = 16'd3; i_data_y = 16'd4;
    tick();
    i_clear = 1'b0; i_start = 1'b0;
    check("clear_ready", o_ready, 1);
    check("clear_enable", o_enable, 0);
    check("clear_init", o_init, 0);
    check("clear_result_kept", o_result, 32'hFFFF_FFFF);
    check("clear_reminder_kept", o_reminder, 32'h0000_1234);
    check("clear_error_kept", o_error, 0);
    check("clear_sel_kept", o_sel, 2'b10);
    check("clear_val_x_kept", o_val_x, 16'd81);
    done_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      if (o_done) done_cnt++;
      tick();
    end
    check("clear_no_done", done_cnt, 0);

    // Asynchronous reset in the middle of RUN.
    i_start = 1'b1; i_op = 2'b01; i_data_x = 16'd1000; i_data_y = 16'd3;
    tick();
    i_start = 1'b0;
    tick(); tick();
    check("pre_rst_enable", o_enable, 1);
    #2 rst = 1'b0;
    #1;
    check("arst_ready", o_ready, 1);
    check("arst_sel", o_sel, 0);
    check("arst_val_x", o_val_x, 0);
    check("arst_val_y", o_val_y, 0);
    check("arst_init", o_init, 0);
    check("arst_enable", o_enable, 0);
    check("arst_counter", o_counter, 0);
    check("arst_result", o_result, 0);
    check("arst_reminder", o_reminder, 0);
    check("arst_done", o_done, 0);
    check("arst_error", o_error, 0);
    @(negedge clk);
    rst = 1'b1;
    tick();
    check("post_rst_done", o_done, 0);

    // Random multiply/divide chain, back-to-back.
    for (int i = 0; i < 4; i++) begin
      rx = 16'($urandom_range(0, 65535));
      ry = 16'($urandom_range(1, 65535));
      if (i % 2 == 0) do_op(2'b00, rx, ry, {16'h0, rx} * {16'h0, ry}, 32'd0, 1'b0, 16, 1'b0);
      else            do_op(2'b01, rx, ry, {16'h0, rx / ry}, {16'h0, rx % ry}, 1'b0, 16, 1'b0);
    end
    tick();
    check("scoreboard_empty", exp_res_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
